// File: rtl/reg_8_bit.sv
// Parallel-load register with load enable and async active-low clear; one-clock load latency, clear acts immediately.
// No flow control: Load is the only qualifier. Optional even-parity output Q_par under REG_8_BIT_PARITY_EN.
// Port order CLK, Load, not_reset, D, Q[, Q_par] is fixed so positional five-port instances keep working.
module reg_8_bit #(
    parameter int                 WIDTH       = 8,
    parameter logic [WIDTH-1:0]   RESET_VALUE = {WIDTH{1'b0}}
) (
    input  logic             CLK,
    input  logic             Load,
    input  logic             not_reset,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q
`ifdef REG_8_BIT_PARITY_EN
    ,
    output logic             Q_par
`endif
);

    always_ff @(posedge CLK or negedge not_reset) begin
        if (!not_reset) begin
            Q <= RESET_VALUE;
        end else if (Load) begin
            Q <= D;
        end
    end

`ifdef REG_8_BIT_PARITY_EN
    // Derived from Q alone, so it tracks the clear value during reset too.
    assign Q_par = ^Q;
`endif

endmodule

// File: tb/tb_reg_8_bit.sv
// Bench for reg_8_bit: directed sequence followed by randomized load/reset traffic.
module tb_reg_8_bit;

    logic       CLK = 1'b0;
    logic       Load;
    logic       not_reset;
    logic [7:0] D;
    logic [7:0] Q;
`ifdef REG_8_BIT_PARITY_EN
    logic       Q_par;
`endif

    int chk_cnt  = 0;
    int pass_cnt = 0;
    logic [7:0] exp_q;

    always #5 CLK = ~CLK;

    reg_8_bit dut (
        .CLK       (CLK),
        .Load      (Load),
        .not_reset (not_reset),
        .D         (D),
        .Q         (Q)
`ifdef REG_8_BIT_PARITY_EN
        ,
        .Q_par     (Q_par)
`endif
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        chk_cnt++;
        if (obs === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic check_par(input string tag);
`ifdef REG_8_BIT_PARITY_EN
        logic [7:0] p;
        p = {7'd0, 1'($countones(exp_q) % 2)};
        check(tag, {7'd0, Q_par}, p);
`endif
    endtask

    task automatic load_and_check(input logic [7:0] val, input string tag);
        @(negedge CLK);
        Load = 1'b1;
        D    = val;
        #2 check({tag, "_pre"}, Q, exp_q);
        @(posedge CLK);
        exp_q = val;
        #1 check(tag, Q, exp_q);
        check_par({tag, "_par"});
    endtask

    initial begin
        logic [7:0] xval;
        xval      = 8'bxxxx_xxxx;
        Load      = 1'b0;
        not_reset = 1'b1;
        D         = 8'h00;

        // Power-up without reset: no spurious load.
        @(posedge CLK);
        #1 check("powerup_x", Q, xval);
        exp_q = xval;

        load_and_check(8'h1A, "ld_1a");
        load_and_check(8'h3A, "ld_3a");
        load_and_check(8'hCA, "ld_ca");
        load_and_check(8'h78, "ld_78");

        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            Load = 1'b0;
            D    = (i % 2 == 0) ? 8'h00 : 8'hFF;
            @(posedge CLK);
            #1 check("hold", Q, exp_q);
        end

        // Mid-cycle reset assertion with Load=1 and D=FF.
        @(negedge CLK);
        Load = 1'b1;
        D    = 8'hFF;
        #2 not_reset = 1'b0;
        exp_q = 8'h00;
        #1 check("rst_async", Q, exp_q);
        check_par("rst_par");
        for (int i = 0; i < 3; i++) begin
            @(posedge CLK);
            #1 check("rst_hold", Q, exp_q);
        end

        @(negedge CLK);
        not_reset = 1'b1;
        Load      = 1'b1;
        D         = 8'h55;
        #1 check("rel_pre", Q, exp_q);
        @(posedge CLK);
        exp_q = 8'h55;
        #1 check("rel_load", Q, exp_q);

        for (int i = 0; i < 300; i++) begin
            @(negedge CLK);
            Load = 1'($urandom);
            D    = 8'($urandom);
            if (!not_reset) begin
                if ($urandom_range(0, 2) == 0) not_reset = 1'b1;
            end else if ($urandom_range(0, 11) == 0) begin
                #2 not_reset = 1'b0;
                exp_q = 8'h00;
                #1 check("rand_rst", Q, exp_q);
            end
            #1 check("rand_between", Q, exp_q);
            @(posedge CLK);
            if (not_reset && Load) exp_q = D;
            #1 check("rand", Q, exp_q);
            check_par("rand_par");
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
